// File: rtl/hd44780_pkg.sv
// Shared constants, state enums and command helpers for the HD44780 character controller.
package hd44780_pkg;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_OFF = 8'h08;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_FS_BASE8 = 8'h30;
  localparam logic [7:0] CMD_FS_BASE4 = 8'h20;
  localparam logic [7:0] CMD_DDRAM    = 8'h80;

  typedef enum logic [2:0] {ST_POR, ST_INIT, ST_IDLE, ST_ADDR, ST_CHAR, ST_DONE} main_st_e;
  typedef enum logic [1:0] {PH_SETUP, PH_EN_HI, PH_HOLD_WAIT} wr_ph_e;

  typedef struct packed {
    logic [7:0] b;
    logic       nib;
    logic       clr;
  } init_cmd_t;

  function automatic logic [7:0] row_base(input logic [1:0] r, input int cols);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(cols);
      default: return 8'(8'h40 + cols);
    endcase
  endfunction

  // 4-bit mode inserts the single 0x2 nibble at index 3, shifting the rest by one.
  function automatic init_cmd_t init_cmd(input logic [3:0] idx, input logic bus4, input logic multi);
    init_cmd_t  c;
    logic [3:0] k;
    c = '{b: CMD_DISP_ON, nib: 1'b0, clr: 1'b0};
    k = (bus4 && idx > 4'd3) ? idx - 4'd1 : idx;
    if (idx < 4'd3) c = '{b: 8'h30, nib: bus4, clr: 1'b1};
    else if (bus4 && idx == 4'd3) c = '{b: 8'h20, nib: 1'b1, clr: 1'b0};
    else begin
      case (k)
        4'd3:    c.b = (bus4 ? CMD_FS_BASE4 : CMD_FS_BASE8) | {4'b0, multi, 3'b0};
        4'd4:    c.b = CMD_DISP_OFF;
        4'd5:    begin c.b = CMD_CLEAR; c.clr = 1'b1; end
        4'd6:    c.b = CMD_ENTRY;
        default: c.b = CMD_DISP_ON;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/hd44780_wr_phy.sv
// Tick divider plus one-byte / one-nibble LCD write sequencer; also times the power-on wait.
module hd44780_wr_phy
  import hd44780_pkg::*;
#(
  parameter int TICK_DIV = 50,
  parameter int BUS4     = 0,
  parameter int WAIT_POR = 40000,
  parameter int WAIT_CMD = 50,
  parameter int WAIT_CLR = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       rs_i,
  input  logic       nib_i,
  input  logic       clr_i,
  output logic       done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o
);

  localparam int WMAX = (WAIT_POR > WAIT_CLR) ? ((WAIT_POR > WAIT_CMD) ? WAIT_POR : WAIT_CMD)
                                              : ((WAIT_CLR > WAIT_CMD) ? WAIT_CLR : WAIT_CMD);
  localparam int WW = $clog2(WMAX + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_q, tick_d;
  logic          tick;
  wr_ph_e        ph_q, ph_d;
  logic          busy_q, busy_d, hi_q, hi_d, nib_q, nib_d, rs_q, rs_d;
  logic [7:0]    byte_q, byte_d;
  logic [WW-1:0] wtgt_q, wtgt_d, wcnt_q, wcnt_d;

  // Out of reset the sequencer is already busy timing the power-on wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      ph_q   <= PH_HOLD_WAIT;
      busy_q <= 1'b1;
      hi_q   <= 1'b0;
      nib_q  <= 1'b0;
      rs_q   <= 1'b0;
      byte_q <= '0;
      wtgt_q <= WW'(WAIT_POR);
      wcnt_q <= '0;
    end else begin
      tick_q <= tick_d;
      ph_q   <= ph_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      nib_q  <= nib_d;
      rs_q   <= rs_d;
      byte_q <= byte_d;
      wtgt_q <= wtgt_d;
      wcnt_q <= wcnt_d;
    end
  end

  always_comb begin
    tick   = (tick_q == TW'(TICK_DIV - 1));
    tick_d = tick ? '0 : tick_q + 1'b1;
    ph_d   = ph_q;
    busy_d = busy_q;
    hi_d   = hi_q;
    nib_d  = nib_q;
    rs_d   = rs_q;
    byte_d = byte_q;
    wtgt_d = wtgt_q;
    wcnt_d = wcnt_q;
    done_o = 1'b0;
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        ph_d   = PH_SETUP;
        byte_d = data_i;
        rs_d   = rs_i;
        nib_d  = nib_i;
        hi_d   = (BUS4 != 0);
        wtgt_d = clr_i ? WW'(WAIT_CLR) : WW'(WAIT_CMD);
        wcnt_d = '0;
      end
    end else if (tick) begin
      case (ph_q)
        PH_SETUP: ph_d = PH_EN_HI;
        PH_EN_HI: begin
          // Full byte in nibble mode: the low nibble's SETUP tick is the gap between pulses.
          if ((BUS4 != 0) && hi_q && !nib_q) begin
            hi_d = 1'b0;
            ph_d = PH_SETUP;
          end else begin
            ph_d   = PH_HOLD_WAIT;
            wcnt_d = '0;
          end
        end
        default: begin
          if (wcnt_q == wtgt_q - 1'b1) begin
            busy_d = 1'b0;
            done_o = 1'b1;
          end else wcnt_d = wcnt_q + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    lcd_en_o   = busy_q && (ph_q == PH_EN_HI);
    lcd_rs_o   = rs_q;
    lcd_data_o = byte_q;
    if (BUS4 != 0) lcd_data_o = {(hi_q ? byte_q[7:4] : byte_q[3:0]), 4'h0};
  end

endmodule

// File: rtl/hd44780_char_ctrl.sv
// HD44780 character-LCD controller: power-on init, then frame-buffer writes to DDRAM on request.
module hd44780_char_ctrl
  import hd44780_pkg::*;
#(
  parameter int TICK_DIV     = 50,
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int BUS4         = 0,
  parameter int AUTO_REFRESH = 0,
  parameter int WAIT_POR     = 40000,
  parameter int WAIT_CMD     = 50,
  parameter int WAIT_CLR     = 2000
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [ROWS*COLS*8-1:0] frame,
  input  logic                   refresh_req,
  output logic                   ready,
  output logic                   frame_done,
  output logic [7:0]             lcd_data,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_en,
  output logic                   lcd_on
);

  localparam int NCH       = ROWS * COLS;
  localparam int RW        = $clog2(ROWS) + 1;
  localparam int CW        = $clog2(COLS) + 1;
  localparam int SW        = $clog2(NCH * 8);
  localparam int INIT_LAST = (BUS4 != 0) ? 8 : 7;

  main_st_e       st_q, st_d;
  logic [3:0]     idx_q, idx_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [NCH*8-1:0] snap_q, snap_d;
  logic           pend_q, pend_d, infl_q, infl_d, on_q;

  logic           start, wr_rs, wr_nib, wr_clr, done;
  logic [7:0]     wr_byte, chr;
  logic [SW-1:0]  sel;
  init_cmd_t      ic;

  hd44780_wr_phy #(
    .TICK_DIV(TICK_DIV), .BUS4(BUS4), .WAIT_POR(WAIT_POR), .WAIT_CMD(WAIT_CMD), .WAIT_CLR(WAIT_CLR)
  ) u_phy (
    .clk(sys_clk), .rst(rst), .start_i(start), .data_i(wr_byte), .rs_i(wr_rs),
    .nib_i(wr_nib), .clr_i(wr_clr), .done_o(done),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_en_o(lcd_en)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_POR;
      idx_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      snap_q <= '0;
      pend_q <= 1'b0;
      infl_q <= 1'b0;
      on_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      row_q  <= row_d;
      col_q  <= col_d;
      snap_q <= snap_d;
      pend_q <= pend_d;
      infl_q <= infl_d;
      on_q   <= 1'b1;
    end
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    row_d  = row_q;
    col_d  = col_q;
    snap_d = snap_q;
    pend_d = pend_q;
    infl_d = infl_q;
    if (start) infl_d = 1'b1;
    if (done)  infl_d = 1'b0;
    // Requests arriving while busy coalesce into one sticky pending frame.
    if (refresh_req && st_q != ST_IDLE) pend_d = 1'b1;
    case (st_q)
      ST_POR: if (done) begin st_d = ST_INIT; idx_d = '0; end
      ST_INIT: if (done) begin
        if (idx_q == 4'(INIT_LAST)) st_d = ST_IDLE;
        else idx_d = idx_q + 4'd1;
      end
      ST_IDLE: if (refresh_req || pend_q) begin
        snap_d = frame; pend_d = 1'b0; row_d = '0; col_d = '0; st_d = ST_ADDR;
      end
      ST_ADDR: if (done) begin st_d = ST_CHAR; col_d = '0; end
      ST_CHAR: if (done) begin
        if (col_q == CW'(COLS - 1)) begin
          col_d = '0;
          if (row_q == RW'(ROWS - 1)) st_d = ST_DONE;
          else begin row_d = row_q + 1'b1; st_d = ST_ADDR; end
        end else col_d = col_q + 1'b1;
      end
      default: begin
        st_d = ST_IDLE;
        if (AUTO_REFRESH != 0) begin
          snap_d = frame; pend_d = 1'b0; row_d = '0; col_d = '0; st_d = ST_ADDR;
        end
      end
    endcase
  end

  always_comb begin
    ic         = init_cmd(idx_q, BUS4 != 0, ROWS > 1);
    sel        = SW'((NCH - 1 - (int'(row_q) * COLS + int'(col_q))) * 8);
    chr        = snap_q[sel +: 8];
    ready      = (st_q == ST_IDLE);
    frame_done = (st_q == ST_DONE);
    lcd_rw     = 1'b0;
    lcd_on     = on_q;
    start      = (st_q == ST_INIT || st_q == ST_ADDR || st_q == ST_CHAR) && !infl_q;
    wr_byte    = chr;
    wr_rs      = 1'b1;
    wr_nib     = 1'b0;
    wr_clr     = 1'b0;
    if (st_q == ST_INIT) begin
      wr_byte = ic.b; wr_rs = 1'b0; wr_nib = ic.nib; wr_clr = ic.clr;
    end else if (st_q == ST_ADDR) begin
      wr_byte = CMD_DDRAM | row_base(2'(row_q), COLS); wr_rs = 1'b0;
    end
  end

endmodule

// File: tb/tb_hd44780_char_ctrl.sv
// Directed bench: an 8-bit 2x16 instance and a 4-bit 4x20 instance share one clock.
module tb_hd44780_char_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, req_a, req_b;
  logic [2*16*8-1:0] frame_a;
  logic [4*20*8-1:0] frame_b;
  logic ready_a, fdone_a, rs_a, rw_a, en_a, on_a;
  logic ready_b, fdone_b, rs_b, rw_b, en_b, on_b;
  logic [7:0] dat_a, dat_b;

  hd44780_char_ctrl #(.TICK_DIV(2), .ROWS(2), .COLS(16), .BUS4(0), .AUTO_REFRESH(0),
    .WAIT_POR(20), .WAIT_CMD(3), .WAIT_CLR(6)) dut_a (
    .sys_clk(clk), .rst(rst_a), .frame(frame_a), .refresh_req(req_a), .ready(ready_a),
    .frame_done(fdone_a), .lcd_data(dat_a), .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_en(en_a), .lcd_on(on_a));

  hd44780_char_ctrl #(.TICK_DIV(2), .ROWS(4), .COLS(20), .BUS4(1), .AUTO_REFRESH(0),
    .WAIT_POR(20), .WAIT_CMD(3), .WAIT_CLR(6)) dut_b (
    .sys_clk(clk), .rst(rst_b), .frame(frame_b), .refresh_req(req_b), .ready(ready_b),
    .frame_done(fdone_b), .lcd_data(dat_b), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_en(en_b), .lcd_on(on_b));

  int checks = 0, errors = 0;

  // Pulse log for A: {rs,data} at en fall, width, data stability, low gap before the rise.
  logic [8:0] pa_q[$];
  int         pa_wid[$], pa_gap[$];
  bit         pa_stab[$];
  logic       a_prev_en = 1'b0;
  logic [7:0] a_prev_dat = 8'h0;
  logic [8:0] a_cur = 9'h0;
  int         a_wid = 0, a_gap = 0, fd_a = 0;
  bit         a_stab = 1'b0;
  logic [8:0] pb_q[$];
  logic       b_prev_en = 1'b0;
  logic [8:0] b_cur = 9'h0;
  int         fd_b = 0;

  always @(negedge clk) begin
    if (en_a && !a_prev_en) begin
      a_cur = {rs_a, dat_a}; a_wid = 1; a_stab = (dat_a == a_prev_dat); pa_gap.push_back(a_gap);
    end else if (en_a) begin
      a_wid++;
      if ({rs_a, dat_a} != a_cur) a_stab = 1'b0;
    end else if (a_prev_en) begin
      pa_q.push_back(a_cur); pa_wid.push_back(a_wid); pa_stab.push_back(a_stab); a_gap = 0;
    end
    if (!en_a) a_gap++;
    if (fdone_a) fd_a++;
    a_prev_en = en_a; a_prev_dat = dat_a;
  end

  always @(negedge clk) begin
    if (en_b) b_cur = {rs_b, dat_b};
    else if (b_prev_en) pb_q.push_back(b_cur);
    if (fdone_b) fd_b++;
    b_prev_en = en_b;
  end

  logic [7:0] init8 [8]  = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [3:0] init4 [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
  logic [7:0] addr_b [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
  string f1 [2] = '{"HELLO WORLD 1234", "FPGA LCD TEST  !"};
  string f2 [2] = '{"PENDING FRAME #2", "NEW DATA ARRIVED"};
  string fb [4] = '{"ROW ZERO abcdefghijk", "ROW ONE  0123456789!", "THIRD LINE ~~~~~~~~~", "fourth line: 4x20 ok"};
  int ref_base = 0;

  task automatic pulse_a();
    @(negedge clk) req_a = 1'b1;
    @(negedge clk) req_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0; frame_a = '0; frame_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dat_a, rs_a, rw_a, en_a, on_a, ready_a, fdone_a} !== 14'h0) begin
      errors++; $display("FAIL reset_a outputs got %h want 0", {dat_a, rs_a, rw_a, en_a, on_a, ready_a, fdone_a});
    end
    checks++;
    if ({dat_b, rs_b, rw_b, en_b, on_b, ready_b, fdone_b} !== 14'h0) begin
      errors++; $display("FAIL reset_b outputs got %h want 0", {dat_b, rs_b, rw_b, en_b, on_b, ready_b, fdone_b});
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({on_a, on_b} !== 2'b11) begin errors++; $display("FAIL lcd_on_after_release got %b want 11", {on_a, on_b}); end
    checks++;
    if ({ready_a, ready_b, en_a, en_b} !== 4'b0) begin
      errors++; $display("FAIL por_quiet got %b want 0000", {ready_a, ready_b, en_a, en_b});
    end
  endtask

  task automatic test_init8();
    for (int n = 0; n < 5000 && !ready_a; n++) @(negedge clk);
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL init8_ready got %b want 1", ready_a); end
    checks++;
    if (pa_q.size() != 8) begin errors++; $display("FAIL init8_count got %0d want 8", pa_q.size()); end
    for (int i = 0; i < 8 && i < pa_q.size(); i++) begin
      checks++;
      if (pa_q[i] !== {1'b0, init8[i]}) begin
        errors++; $display("FAIL init8_byte%0d got %h want %h", i, pa_q[i], {1'b0, init8[i]});
      end
    end
  endtask

  task automatic test_refresh();
    int fd0;
    ref_base = pa_q.size(); fd0 = fd_a;
    frame_a = {"HELLO WORLD 1234", "FPGA LCD TEST  !"};
    pulse_a();
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL refresh_ready_drop got %b want 0", ready_a); end
    for (int n = 0; n < 5000 && fd_a == fd0; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (fd_a - fd0 != 1) begin errors++; $display("FAIL refresh_done_pulses got %0d want 1", fd_a - fd0); end
    checks++;
    if (ready_a !== 1'b1) begin errors++; $display("FAIL refresh_ready_back got %b want 1", ready_a); end
    checks++;
    if (pa_q.size() - ref_base != 34) begin
      errors++; $display("FAIL refresh_count got %0d want 34", pa_q.size() - ref_base);
    end
    for (int r = 0; r < 2 && pa_q.size() >= ref_base + 34; r++) begin
      string s;
      s = f1[r];
      checks++;
      if (pa_q[ref_base + r*17] !== {1'b0, (r == 0) ? 8'h80 : 8'hC0}) begin
        errors++; $display("FAIL refresh_addr%0d got %h", r, pa_q[ref_base + r*17]);
      end
      for (int c = 0; c < 16; c++) begin
        checks++;
        if (pa_q[ref_base + r*17 + 1 + c] !== {1'b1, s[c]}) begin
          errors++; $display("FAIL refresh_char r%0d c%0d got %h want %h", r, c, pa_q[ref_base + r*17 + 1 + c], {1'b1, s[c]});
        end
      end
    end
  endtask

  task automatic test_timing();
    for (int i = 0; i < pa_q.size(); i++) begin
      checks++;
      if (pa_wid[i] != 2 || !pa_stab[i]) begin
        errors++; $display("FAIL timing_pulse%0d width %0d stable %0d want 2 1", i, pa_wid[i], pa_stab[i]);
      end
    end
    for (int i = ref_base + 1; i < pa_q.size(); i++) begin
      if (pa_q[i-1][8]) begin
        checks++;
        if (pa_gap[i] < 6) begin errors++; $display("FAIL timing_char_gap%0d got %0d want >=6", i, pa_gap[i]); end
      end
    end
    checks++;
    if (pa_gap[6] < 12) begin errors++; $display("FAIL timing_clear_gap got %0d want >=12", pa_gap[6]); end
    checks++;
    if (pa_gap[1] < 12 || pa_gap[3] < 12) begin
      errors++; $display("FAIL timing_init30_gap got %0d %0d want >=12", pa_gap[1], pa_gap[3]);
    end
  endtask

  task automatic test_bus4();
    int fd0, base;
    for (int n = 0; n < 5000 && !ready_b; n++) @(negedge clk);
    checks++;
    if (pb_q.size() != 14) begin errors++; $display("FAIL bus4_init_count got %0d want 14", pb_q.size()); end
    for (int i = 0; i < 14 && i < pb_q.size(); i++) begin
      checks++;
      if (pb_q[i] !== {1'b0, init4[i], 4'h0}) begin
        errors++; $display("FAIL bus4_init%0d got %h want %h", i, pb_q[i], {1'b0, init4[i], 4'h0});
      end
    end
    base = pb_q.size(); fd0 = fd_b;
    frame_b = {"ROW ZERO abcdefghijk", "ROW ONE  0123456789!", "THIRD LINE ~~~~~~~~~", "fourth line: 4x20 ok"};
    @(negedge clk) req_b = 1'b1;
    @(negedge clk) req_b = 1'b0;
    for (int n = 0; n < 10000 && fd_b == fd0; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (fd_b - fd0 != 1 || ready_b !== 1'b1) begin
      errors++; $display("FAIL bus4_done got %0d ready %b want 1 1", fd_b - fd0, ready_b);
    end
    checks++;
    if (pb_q.size() - base != 168) begin errors++; $display("FAIL bus4_count got %0d want 168", pb_q.size() - base); end
    for (int i = base; i < pb_q.size(); i++) begin
      checks++;
      if (pb_q[i][3:0] !== 4'h0) begin errors++; $display("FAIL bus4_low_zero%0d got %h want 0", i, pb_q[i][3:0]); end
    end
    for (int r = 0; r < 4 && pb_q.size() >= base + 168; r++) begin
      string s;
      int    p;
      s = fb[r]; p = base + r*42;
      checks++;
      if ({pb_q[p][8], pb_q[p][7:4], pb_q[p+1][7:4]} !== {1'b0, addr_b[r]}) begin
        errors++; $display("FAIL bus4_addr%0d got %h%h want %h", r, pb_q[p][7:4], pb_q[p+1][7:4], addr_b[r]);
      end
      for (int c = 0; c < 20; c++) begin
        p = base + r*42 + 2 + 2*c;
        checks++;
        if ({pb_q[p][8], pb_q[p+1][8], pb_q[p][7:4], pb_q[p+1][7:4]} !== {2'b11, s[c]}) begin
          errors++; $display("FAIL bus4_char r%0d c%0d got %h%h want %h", r, c, pb_q[p][7:4], pb_q[p+1][7:4], s[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd0, base;
    base = pa_q.size(); fd0 = fd_a;
    frame_a = {"HELLO WORLD 1234", "FPGA LCD TEST  !"};
    pulse_a();
    for (int n = 0; n < 2000 && pa_q.size() < base + 3; n++) @(negedge clk);
    frame_a = {"PENDING FRAME #2", "NEW DATA ARRIVED"};
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(negedge clk);
      checks++;
      if (ready_a !== 1'b0) begin errors++; $display("FAIL pend_busy%0d got %b want 0", k, ready_a); end
      pulse_a();
    end
    for (int n = 0; n < 10000 && fd_a < fd0 + 2; n++) @(negedge clk);
    repeat (300) @(negedge clk);
    checks++;
    if (fd_a - fd0 != 2) begin errors++; $display("FAIL pend_frames got %0d want 2", fd_a - fd0); end
    checks++;
    if (pa_q.size() - base != 68 || ready_a !== 1'b1) begin
      errors++; $display("FAIL pend_count got %0d ready %b want 68 1", pa_q.size() - base, ready_a);
    end
    for (int f = 0; f < 2 && pa_q.size() >= base + 68; f++) begin
      for (int r = 0; r < 2; r++) begin
        string s;
        s = (f == 0) ? f1[r] : f2[r];
        for (int c = 0; c < 16; c++) begin
          checks++;
          if (pa_q[base + f*34 + r*17 + 1 + c] !== {1'b1, s[c]}) begin
            errors++; $display("FAIL pend_char f%0d r%0d c%0d got %h want %h", f, r, c, pa_q[base + f*34 + r*17 + 1 + c], {1'b1, s[c]});
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, rises;
    pulse_a();
    for (int n = 0; n < 2000 && !(en_a && rs_a); n++) @(negedge clk);
    checks++;
    if (!(en_a && rs_a)) begin errors++; $display("FAIL mid_char_enhi got %b want 11", {en_a, rs_a}); end
    #1 rst_a = 1'b1;
    #1;
    checks++;
    if ({en_a, on_a, ready_a} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_drop got %b want 000", {en_a, on_a, ready_a});
    end
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    base = pa_q.size(); rises = pa_gap.size();
    repeat (40) @(negedge clk);
    checks++;
    if (pa_gap.size() != rises) begin errors++; $display("FAIL mid_por_quiet got %0d pulses want 0", pa_gap.size() - rises); end
    for (int n = 0; n < 5000 && !ready_a; n++) @(negedge clk);
    checks++;
    if (pa_q.size() - base != 8) begin errors++; $display("FAIL mid_reinit_count got %0d want 8", pa_q.size() - base); end
    for (int i = 0; i < 8 && base + i < pa_q.size(); i++) begin
      checks++;
      if (pa_q[base + i] !== {1'b0, init8[i]}) begin
        errors++; $display("FAIL mid_reinit%0d got %h want %h", i, pa_q[base + i], {1'b0, init8[i]});
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init8();
    test_refresh();
    test_timing();
    test_bus4();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
